memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- Pipeline MEM stage of the 5-stage RV32I core; consumes the execute/memory pipeline bundle (RegWriteM, ResultSrcM, MemWriteM, MemoryOpM, ALUResultM, WriteDataM, RdM, PCPlus4M).
- Drives a ready-handshaked data-memory port with byte lanes, and aligns/extends load data.
- Stalls upstream on wait states and holds the MEM/WB pipeline register feeding writeback.
- Flags misaligned accesses and memory timeouts.

Parameters:
DATA_WIDTH, 32, data/address width
ADDR_WIDTH, 5, register index width
TIMEOUT_CYCLES, 16, max wait cycles before bus error (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
RegWriteM  in  1  register write enable from EX/MEM
ResultSrcM  in  2  result select; 2'b01 = load
MemWriteM  in  1  store enable
MemoryOpM  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
ALUResultM  in  DATA_WIDTH  effective address / ALU result
WriteDataM  in  DATA_WIDTH  store data (unshifted)
RdM  in  ADDR_WIDTH  destination register
PCPlus4M  in  DATA_WIDTH  PC+4
mem_req  out  1  access request
mem_we  out  1  write strobe
mem_addr  out  DATA_WIDTH  word-aligned address ({ALUResultM[31:2],2'b00})
mem_wdata  out  DATA_WIDTH  lane-replicated store data
mem_be  out  4  byte enables
mem_ready  in  1  access completes this cycle
mem_rdata  in  DATA_WIDTH  read word, valid with mem_ready
StallM  out  1  hold IF/ID/EX/MEM registers
misaligned  out  1  one-cycle misaligned-access pulse
bus_error  out  1  one-cycle timeout pulse
RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W  out  1/2/DW/DW/AW/DW  MEM/WB register outputs

Behaviour:
- Access = load (ResultSrcM==01) or MemWriteM. Neither set: no mem_req, no stall, pass-through.
- Misalignment: H/HU with addr[0]=1; W with addr[1:0]!=0.
  - No mem_req issued.
  - misaligned pulses in the capture cycle.
  - W register loads with RegWriteW=0.
- FSM IDLE/WAIT; state register reset to IDLE.
  - IDLE: aligned access drives mem_req=1 combinationally.
    - mem_ready=1: complete that cycle, StallM=0 (zero-wait).
    - Else: StallM=1, go WAIT, wait counter=1.
  - WAIT: mem_req held; mem_addr/wdata/be stable (inputs held by stall).
    - mem_ready: complete, StallM=0, go IDLE.
    - Counter reaches TIMEOUT_CYCLES without ready: bus_error pulse, drop request, W loads with RegWriteW=0, go IDLE, StallM=0.
- Store lanes:
  - SB: wdata={4{b}}, be=0001<<addr[1:0].
  - SH: wdata={2{h}}, be=0011<<addr[1:0].
  - SW: be=1111.
  - Undefined MemoryOp encodings are treated as W.
- Load extract from mem_rdata by addr[1:0]:
  - B/H sign-extend; BU/HU zero-extend; W unchanged.
- MEM/WB register:
  - Updates every cycle StallM=0.
  - While StallM=1: loads a bubble (RegWriteW=0, ResultSrcW=00, others don't-care), so writeback never retires twice.
- Reset (async, any time incl. mid-WAIT):
  - FSM→IDLE, counter=0.
  - mem_req, mem_we, StallM, misaligned, bus_error → 0 (combinational outputs follow).
  - All W outputs = 0; mem_be = 0.
- Completion with mem_ready in same cycle as timeout limit: completion wins, no bus_error.

Decomposition:
- Package mem_stage_pkg:
  - MemoryOp funct3 localparams.
  - RESULT_LOAD=2'b01.
  - State enum {IDLE, WAIT}.
- Sub-module load_store_align (combinational): WriteDataM/MemoryOp/addr → wdata, be, misaligned; mem_rdata → formatted ReadData.
- memory_stage holds the FSM, counter and W register.

Test Plan:
- SB addr 0x1003 data 0x000000A5, mem_ready=1 → mem_be=1000, mem_wdata=0xA5A5A5A5, StallM=0, RegWriteW=0 next cycle.
- LB addr 0x2001, rdata 0x0000_8000, ready same cycle → ReadDataW=0xFFFFFF80; LBU same → 0x00000080.
- LW addr 0x3000, mem_ready low 3 cycles → StallM=1 for 3 cycles, W bubbles meanwhile, ReadDataW=rdata on cycle 4, single retirement.
- LH addr 0x4001 → no mem_req, misaligned=1 for one cycle, RegWriteW=0.
- LW with mem_ready never asserted, TIMEOUT_CYCLES=16 → bus_error pulses after 16 wait cycles, StallM drops, RegWriteW=0.
- rst_n low during WAIT → StallM, mem_req, all W outputs 0 immediately; FSM IDLE after release.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared constants and FSM state type for the RV32I MEM stage.
package mem_stage_pkg;

  localparam logic [2:0] MEM_OP_B  = 3'b000;
  localparam logic [2:0] MEM_OP_H  = 3'b001;
  localparam logic [2:0] MEM_OP_W  = 3'b010;
  localparam logic [2:0] MEM_OP_BU = 3'b100;
  localparam logic [2:0] MEM_OP_HU = 3'b101;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  typedef enum logic {IDLE, WAIT} mem_state_t;

endpackage

// File: rtl/memory_stage_align.sv
// Byte-lane steering for stores and alignment/extension of load data.
module load_store_align
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            memoryOp,
  input  logic [1:0]            addrLow,
  input  logic [DATA_WIDTH-1:0] storeData,
  input  logic [DATA_WIDTH-1:0] readWord,
  output logic [DATA_WIDTH-1:0] storeWord,
  output logic [3:0]            byteEnable,
  output logic                  misaligned,
  output logic [DATA_WIDTH-1:0] loadData
);

  logic [DATA_WIDTH-1:0] laneShifted;
  logic [7:0]            loadByte;
  logic [15:0]           loadHalf;

  assign laneShifted = readWord >> {addrLow, 3'b000};
  assign loadByte    = laneShifted[7:0];
  assign loadHalf    = laneShifted[15:0];

  always_comb begin
    storeWord  = storeData;
    byteEnable = 4'b1111;
    misaligned = (addrLow != 2'b00);
    loadData   = readWord;
    case (memoryOp)
      MEM_OP_B, MEM_OP_BU: begin
        storeWord  = {4{storeData[7:0]}};
        byteEnable = 4'b0001 << addrLow;
        misaligned = 1'b0;
        loadData   = (memoryOp == MEM_OP_B) ? {{(DATA_WIDTH-8){loadByte[7]}}, loadByte}
                                            : {{(DATA_WIDTH-8){1'b0}}, loadByte};
      end
      MEM_OP_H, MEM_OP_HU: begin
        storeWord  = {2{storeData[15:0]}};
        byteEnable = 4'b0011 << addrLow;
        misaligned = addrLow[0];
        loadData   = (memoryOp == MEM_OP_H) ? {{(DATA_WIDTH-16){loadHalf[15]}}, loadHalf}
                                            : {{(DATA_WIDTH-16){1'b0}}, loadHalf};
      end
      default: ; // undefined encodings behave as word accesses
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// MEM stage: data-memory handshake FSM with timeout, stall generation and MEM/WB register.
module memory_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RegWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic                  MemWriteM,
  input  logic [2:0]            MemoryOpM,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic [ADDR_WIDTH-1:0] RdM,
  input  logic [DATA_WIDTH-1:0] PCPlus4M,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  StallM,
  output logic                  misaligned,
  output logic                  bus_error,
  output logic                  RegWriteW,
  output logic [1:0]            ResultSrcW,
  output logic [DATA_WIDTH-1:0] ALUResultW,
  output logic [DATA_WIDTH-1:0] ReadDataW,
  output logic [ADDR_WIDTH-1:0] RdW,
  output logic [DATA_WIDTH-1:0] PCPlus4W
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  mem_state_t       stateReg, stateNext;
  logic [CNT_W-1:0] waitCountReg, waitCountNext;

  logic                  isAccess;
  logic                  alignMis;
  logic [3:0]            laneBe;
  logic [DATA_WIDTH-1:0] loadData;
  logic                  memReq, stall, timeoutHit, misPulse;

  assign isAccess = (ResultSrcM == RESULT_LOAD) || MemWriteM;

  load_store_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .memoryOp  (MemoryOpM),
    .addrLow   (ALUResultM[1:0]),
    .storeData (WriteDataM),
    .readWord  (mem_rdata),
    .storeWord (mem_wdata),
    .byteEnable(laneBe),
    .misaligned(alignMis),
    .loadData  (loadData)
  );

  // Outputs are forced quiet while reset is held so nothing reaches the bus.
  always_comb begin
    stateNext     = stateReg;
    waitCountNext = waitCountReg;
    memReq        = 1'b0;
    stall         = 1'b0;
    timeoutHit    = 1'b0;
    misPulse      = 1'b0;
    if (rst_n) begin
      case (stateReg)
        IDLE: begin
          if (isAccess) begin
            if (alignMis) begin
              misPulse = 1'b1;
            end else begin
              memReq = 1'b1;
              if (!mem_ready) begin
                stall         = 1'b1;
                stateNext     = WAIT;
                waitCountNext = CNT_W'(1);
              end
            end
          end
        end
        WAIT: begin
          memReq = 1'b1;
          if (mem_ready) begin
            stateNext     = IDLE;
            waitCountNext = '0;
          end else if (waitCountReg >= CNT_W'(TIMEOUT_CYCLES)) begin
            timeoutHit    = 1'b1;
            stateNext     = IDLE;
            waitCountNext = '0;
          end else begin
            stall         = 1'b1;
            waitCountNext = waitCountReg + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign mem_req    = memReq;
  assign mem_we     = memReq & MemWriteM;
  assign mem_be     = memReq ? laneBe : 4'b0000;
  assign mem_addr   = {ALUResultM[DATA_WIDTH-1:2], 2'b00};
  assign StallM     = stall;
  assign misaligned = misPulse;
  assign bus_error  = timeoutHit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg     <= IDLE;
      waitCountReg <= '0;
    end else begin
      stateReg     <= stateNext;
      waitCountReg <= waitCountNext;
    end
  end

  // A stalled cycle inserts a bubble so the held instruction retires exactly once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      RdW        <= '0;
      PCPlus4W   <= '0;
    end else if (stall) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
    end else begin
      RegWriteW  <= RegWriteM & ~misPulse & ~timeoutHit;
      ResultSrcW <= ResultSrcM;
      ALUResultW <= ALUResultM;
      ReadDataW  <= loadData;
      RdW        <= RdM;
      PCPlus4W   <= PCPlus4M;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed plus randomized checks of memory_stage against a cycle-count reference model.
module tb_memory_stage;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  MemoryOpM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        StallM, misaligned, bus_error;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RdW;

  int total = 0;
  int bad   = 0;
  int txNum = 0;

  memory_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .MemoryOpM(MemoryOpM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .RdM(RdM), .PCPlus4M(PCPlus4M),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .StallM(StallM), .misaligned(misaligned), .bus_error(bus_error),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
    .ReadDataW(ReadDataW), .RdW(RdW), .PCPlus4W(PCPlus4W)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] refLoad(input logic [2:0] op, input int a, input logic [31:0] w);
    logic [31:0] v;
    int          b;
    v = w >> (a * 8);
    case (op)
      3'd0: begin b = int'(v & 32'd255);   if (b >= 128)   b -= 256;   return 32'(b); end
      3'd4: return v & 32'd255;
      3'd1: begin b = int'(v & 32'd65535); if (b >= 32768) b -= 65536; return 32'(b); end
      3'd5: return v & 32'd65535;
      default: return w;
    endcase
  endfunction

  // Called and returns at posedge+1; lat = cycle (0-based) in which mem_ready is given.
  task automatic runTx(input string name, input logic ld, input logic st, input logic rw,
                       input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rdv, input logic [4:0] rd, input logic [31:0] pc,
                       input int lat);
    int          a, last;
    logic        isByte, isHalf, mis, access, req, tmo, expStall;
    logic [31:0] expWdata;
    logic [3:0]  expBe;
    a      = int'(addr[1:0]);
    isByte = (op == 3'd0) || (op == 3'd4);
    isHalf = (op == 3'd1) || (op == 3'd5);
    access = ld || st;
    mis    = access && (isHalf ? addr[0] : (!isByte && a != 0));
    req    = access && !mis;
    tmo    = req && (lat > T);
    last   = !req ? 0 : (tmo ? T : lat);
    expWdata = isByte ? (wd & 32'd255) * 32'h01010101 :
               isHalf ? (wd & 32'd65535) * 32'h00010001 : wd;
    expBe    = isByte ? 4'(1 << a) : isHalf ? 4'(3 << a) : 4'd15;

    RegWriteM  = rw;
    ResultSrcM = ld ? 2'b01 : (st ? 2'b00 : 2'(($urandom_range(0, 1)) * 2));
    MemWriteM  = st;
    MemoryOpM  = op;
    ALUResultM = addr;
    WriteDataM = wd;
    RdM        = rd;
    PCPlus4M   = pc;
    $display("tx %0d %s ld=%0b st=%0b op=%0d addr=%08h lat=%0d", txNum, name, ld, st, op, addr, lat);
    txNum++;

    for (int k = 0; k <= T; k++) begin
      mem_ready = req && (k == lat);
      mem_rdata = (k == lat) ? rdv : $urandom;
      expStall  = req && (k < last);
      @(negedge clk);
      check({name, ".req"},   {31'd0, mem_req},    {31'd0, req});
      check({name, ".stall"}, {31'd0, StallM},     {31'd0, expStall});
      check({name, ".mis"},   {31'd0, misaligned}, {31'd0, mis && k == 0});
      check({name, ".berr"},  {31'd0, bus_error},  {31'd0, tmo && k == T});
      if (req) begin
        check({name, ".we"},   {31'd0, mem_we}, {31'd0, st});
        check({name, ".addr"}, mem_addr, addr & 32'hFFFF_FFFC);
        if (st) begin
          check({name, ".be"},    {28'd0, mem_be}, {28'd0, expBe});
          check({name, ".wdata"}, mem_wdata, expWdata);
        end
      end
      @(posedge clk); #1;
      if (expStall) begin
        check({name, ".bubbleRW"}, {31'd0, RegWriteW},  32'd0);
        check({name, ".bubbleRS"}, {30'd0, ResultSrcW}, 32'd0);
      end else begin
        check({name, ".RegWriteW"},  {31'd0, RegWriteW},  {31'd0, rw && !mis && !tmo});
        check({name, ".ResultSrcW"}, {30'd0, ResultSrcW}, {30'd0, ResultSrcM});
        check({name, ".ALUResultW"}, ALUResultW, addr);
        check({name, ".RdW"},        {27'd0, RdW}, {27'd0, rd});
        check({name, ".PCPlus4W"},   PCPlus4W, pc);
        if (ld && req && !tmo) check({name, ".ReadDataW"}, ReadDataW, refLoad(op, a, rdv));
        break;
      end
    end
    mem_ready = 1'b0;
  endtask

  initial begin
    logic [2:0] opTab [8];
    logic [2:0] op;
    logic       ld, st;
    int         lat;
    opTab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd2, 3'd3};

    // Reset with a load presented: nothing may reach the bus.
    rst_n = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    RegWriteM = 1'b1; ResultSrcM = 2'b01; MemWriteM = 1'b0; MemoryOpM = 3'd2;
    ALUResultM = 32'h100; WriteDataM = '0; RdM = 5'd3; PCPlus4M = 32'h44;
    repeat (2) @(posedge clk);
    #1;
    check("rst.req",   {31'd0, mem_req},   32'd0);
    check("rst.stall", {31'd0, StallM},    32'd0);
    check("rst.be",    {28'd0, mem_be},    32'd0);
    check("rst.RW",    {31'd0, RegWriteW}, 32'd0);
    check("rst.PC",    PCPlus4W,           32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    runTx("SB",   1'b0, 1'b1, 1'b0, 3'd0, 32'h1003, 32'h0000_00A5, 32'h0,        5'd0, 32'h10, 0);
    runTx("LB",   1'b1, 1'b0, 1'b1, 3'd0, 32'h2001, 32'h0,        32'h0000_8000, 5'd5, 32'h14, 0);
    runTx("LBU",  1'b1, 1'b0, 1'b1, 3'd4, 32'h2001, 32'h0,        32'h0000_8000, 5'd6, 32'h18, 0);
    runTx("LW3",  1'b1, 1'b0, 1'b1, 3'd2, 32'h3000, 32'h0,        32'hDEAD_BEEF, 5'd7, 32'h1C, 3);
    runTx("LHmis",1'b1, 1'b0, 1'b1, 3'd1, 32'h4001, 32'h0,        32'h0,        5'd8, 32'h20, 0);
    runTx("LWtmo",1'b1, 1'b0, 1'b1, 3'd2, 32'h5000, 32'h0,        32'h1234_5678, 5'd9, 32'h24, T + 5);
    runTx("LWedge",1'b1,1'b0, 1'b1, 3'd2, 32'h5004, 32'h0,        32'hCAFE_F00D, 5'd10, 32'h28, T);
    runTx("SH",   1'b0, 1'b1, 1'b0, 3'd1, 32'h6002, 32'h0000_BEEF, 32'h0,       5'd0, 32'h2C, 1);
    runTx("ALU",  1'b0, 1'b0, 1'b1, 3'd2, 32'h7777, 32'h0,        32'h0,        5'd11, 32'h30, 0);

    // Reset in the middle of a wait sequence.
    RegWriteM = 1'b1; ResultSrcM = 2'b01; MemWriteM = 1'b0; MemoryOpM = 3'd2;
    ALUResultM = 32'h3000; mem_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("midwait.stall", {31'd0, StallM}, 32'd1);
    rst_n = 1'b0; #1;
    check("rstwait.stall", {31'd0, StallM},   32'd0);
    check("rstwait.req",   {31'd0, mem_req},  32'd0);
    check("rstwait.be",    {28'd0, mem_be},   32'd0);
    check("rstwait.ALU",   ALUResultW,        32'd0);
    check("rstwait.PC",    PCPlus4W,          32'd0);
    check("rstwait.Rd",    {27'd0, RdW},      32'd0);
    @(negedge clk); rst_n = 1'b1; ResultSrcM = 2'b00;
    @(posedge clk); #1;
    runTx("postRst", 1'b1, 1'b0, 1'b1, 3'd2, 32'h3000, 32'h0, 32'h0BAD_F00D, 5'd12, 32'h34, 2);

    for (int i = 0; i < 40; i++) begin
      op = opTab[$urandom_range(0, 7)];
      ld = ($urandom_range(0, 2) == 0);
      st = !ld && ($urandom_range(0, 1) == 1);
      lat = ($urandom_range(0, 9) == 0) ? T + int'($urandom_range(0, 1)) : int'($urandom_range(0, 3));
      runTx("rnd", ld, st, 1'($urandom), op, $urandom, $urandom, $urandom,
            5'($urandom), $urandom, lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
